// File: rtl/count_ctrl_pkg.sv
// Shared types and constants for the count_ctrl run sequencer.
// Analog-style levels are carried as fixed-point codes (0 = ground).
package count_ctrl_pkg;

  localparam int XW = 8;
  localparam int TH_SCALE = 256;
  localparam int CW_DEF = 3;

  typedef logic [XW-1:0] xreal_t;

  localparam xreal_t X_GND = '0;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_e;

  // Threshold fraction as an integer numerator over TH_SCALE.
  function automatic int th_num(real frac);
    if (frac <= 0.0) return 0;
    if (frac >= 1.0) return TH_SCALE;
    return int'(frac * real'(TH_SCALE));
  endfunction

endpackage

// File: rtl/count_ctrl_xr2bit.sv
// Level comparator: one analog-style node to one logic bit.
// High when the node sits strictly above VTH_FRAC * VDD.
module xr2bit
  import count_ctrl_pkg::*;
#(
  parameter real VTH_FRAC = 0.5
) (
  input  xreal_t x,
  input  xreal_t vdd,
  output logic   b
);

  localparam int NUM = th_num(VTH_FRAC);

  logic [16:0] lhs;
  logic [16:0] rhs;

  assign lhs = {1'b0, x, 8'h00};
  assign rhs = 17'(vdd) * 17'(NUM);
  assign b   = lhs > rhs;

endmodule

// File: rtl/count_ctrl.sv
// Run sequencer for an external ripple-enable counter.
// Enables N counts, checks observed Q every edge, pulses DONE.
module count_ctrl
  import count_ctrl_pkg::*;
#(
  parameter int  CW       = CW_DEF,
  parameter real VTH_FRAC = 0.5
) (
  input  xreal_t          CK,
  input  xreal_t          RN,
  input  xreal_t          VDD,
  input  xreal_t          START,
  input  xreal_t [CW-1:0] STEPS,
  input  xreal_t          PAUSE,
  input  xreal_t          ABORT,
  input  xreal_t [CW-1:0] Q,
  output xreal_t          EN,
  output xreal_t          BUSY,
  output xreal_t          DONE,
  output xreal_t          ERR
);

  logic          ck;
  logic          rn;
  logic          start_b;
  logic          pause_b;
  logic          abort_b;
  logic [CW-1:0] steps_b;
  logic [CW-1:0] q_b;

  xr2bit #(.VTH_FRAC(VTH_FRAC)) u_ck (
    .x(CK), .vdd(VDD), .b(ck)
  );
  xr2bit #(.VTH_FRAC(VTH_FRAC)) u_rn (
    .x(RN), .vdd(VDD), .b(rn)
  );
  xr2bit #(.VTH_FRAC(VTH_FRAC)) u_st (
    .x(START), .vdd(VDD), .b(start_b)
  );
  xr2bit #(.VTH_FRAC(VTH_FRAC)) u_pa (
    .x(PAUSE), .vdd(VDD), .b(pause_b)
  );
  xr2bit #(.VTH_FRAC(VTH_FRAC)) u_ab (
    .x(ABORT), .vdd(VDD), .b(abort_b)
  );

  for (genvar i = 0; i < CW; i++) begin : g_bits
    xr2bit #(.VTH_FRAC(VTH_FRAC)) u_steps (
      .x(STEPS[i]), .vdd(VDD), .b(steps_b[i])
    );
    xr2bit #(.VTH_FRAC(VTH_FRAC)) u_q (
      .x(Q[i]), .vdd(VDD), .b(q_b[i])
    );
  end

  state_e        state_q, state_d;
  logic          en_q, en_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [CW:0]   rem_q, rem_d;
  logic [CW-1:0] exp_q, exp_d;
  logic          mism;
  logic          last;

  assign mism = q_b != exp_q;
  assign last = en_q && (rem_q == (CW+1)'(1));

  always_comb begin
    state_d = state_q;
    en_d    = en_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    rem_d   = rem_q;
    exp_d   = exp_q;
    if (abort_b) begin
      state_d = IDLE;
      en_d    = 1'b0;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_b) begin
            state_d = RUN;
            rem_d   = (steps_b == '0)
                    ? {1'b1, {CW{1'b0}}}
                    : {1'b0, steps_b};
            exp_d   = q_b;
            err_d   = 1'b0;
            busy_d  = 1'b1;
            en_d    = 1'b1;
          end
        end
        RUN: begin
          if (mism) err_d = 1'b1;
          if (en_q) begin
            exp_d = exp_q + CW'(1);
            rem_d = rem_q - (CW+1)'(1);
          end
          en_d = !pause_b && !last;
          if (last) state_d = DRAIN;
        end
        DRAIN: begin
          if (mism) err_d = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          en_d    = 1'b0;
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          en_d    = 1'b0;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge ck or negedge rn) begin
    if (!rn) begin
      state_q <= IDLE;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rem_q   <= '0;
      exp_q   <= '0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rem_q   <= rem_d;
      exp_q   <= exp_d;
    end
  end

  // Full-rail output levels only.
  assign EN   = en_q   ? VDD : X_GND;
  assign BUSY = busy_q ? VDD : X_GND;
  assign DONE = done_q ? VDD : X_GND;
  assign ERR  = err_q  ? VDD : X_GND;

endmodule

// File: tb/tb_count_ctrl.sv
// Directed bench for count_ctrl with a behavioural counter on Q.
// Checks levels, run timing, pause, wrap, mismatch, abort, reset.
module tb_count_ctrl;
  import count_ctrl_pkg::*;

  localparam xreal_t HI = 8'd200;
  localparam xreal_t LO = 8'd0;

  logic         clk;
  xreal_t       CK, RN, VDD, START, PAUSE, ABORT;
  xreal_t [2:0] STEPS, Q;
  xreal_t       EN, BUSY, DONE, ERR;

  logic [2:0] steps_v;
  logic [2:0] q_cnt;
  logic [2:0] stuck_v;
  logic       stuck;
  logic       e_s;
  int         cyc, t0, en_edges;
  int         checks, errors;
  int         dt, seen;

  count_ctrl #(.CW(3), .VTH_FRAC(0.5)) dut (
    .CK(CK), .RN(RN), .VDD(VDD), .START(START),
    .STEPS(STEPS), .PAUSE(PAUSE), .ABORT(ABORT),
    .Q(Q), .EN(EN), .BUSY(BUSY), .DONE(DONE),
    .ERR(ERR)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign CK  = clk ? HI : LO;
  assign VDD = HI;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      STEPS[i] = steps_v[i] ? HI : LO;
      Q[i] = (stuck ? stuck_v[i] : q_cnt[i]) ? HI : LO;
    end
  end

  function automatic int lvl(xreal_t x);
    if (x == HI) return 1;
    if (x == LO) return 0;
    return 2;
  endfunction

  task automatic chk(string tag, int got, int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  // Counter advances on edges where EN was high before the edge.
  task automatic tick();
    @(posedge clk);
    e_s = (lvl(EN) == 1);
    #1;
    if (e_s) begin
      q_cnt = q_cnt + 3'd1;
      en_edges++;
    end
    cyc++;
    #1;
  endtask

  task automatic start_run(input logic [2:0] st);
    steps_v  = st;
    START    = HI;
    en_edges = 0;
    tick();
    START = LO;
    t0 = cyc;
  endtask

  task automatic wait_done(input int lim, output int d);
    d = -1;
    for (int i = 0; i < lim && d < 0; i++) begin
      tick();
      if (lvl(DONE) == 1) d = cyc - t0;
    end
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; en_edges = 0;
    RN = HI; START = LO; PAUSE = LO; ABORT = LO;
    steps_v = 3'd0; q_cnt = 3'd0;
    stuck = 1'b0; stuck_v = 3'd0;
    #1 RN = LO;
    #1;
    chk("rst_en",   lvl(EN),   0);
    chk("rst_busy", lvl(BUSY), 0);
    chk("rst_done", lvl(DONE), 0);
    chk("rst_err",  lvl(ERR),  0);
    @(posedge clk);
    #2 RN = HI;
    tick();
    chk("idle_busy", lvl(BUSY), 0);

    // nominal 5 steps
    q_cnt = 3'd0;
    start_run(3'd5);
    chk("nom_en0",   lvl(EN),   1);
    chk("nom_busy0", lvl(BUSY), 1);
    wait_done(20, dt);
    chk("nom_done_t", dt, 6);
    chk("nom_edges", en_edges, 5);
    chk("nom_q", int'(q_cnt), 5);
    chk("nom_err", lvl(ERR), 0);
    chk("nom_busy_d", lvl(BUSY), 0);
    tick();
    chk("nom_done_w", lvl(DONE), 0);

    // wrap with STEPS=0
    q_cnt = 3'd6;
    start_run(3'd0);
    wait_done(20, dt);
    chk("wrap_done_t", dt, 9);
    chk("wrap_edges", en_edges, 8);
    chk("wrap_q", int'(q_cnt), 6);
    chk("wrap_err", lvl(ERR), 0);
    tick();

    // pause for 3 cycles after 2nd enabled edge
    q_cnt = 3'd0;
    start_run(3'd4);
    tick(); tick();
    PAUSE = HI;
    tick();
    chk("pau_en_t3", lvl(EN), 0);
    tick(); tick();
    chk("pau_en_t5", lvl(EN), 0);
    PAUSE = LO;
    tick();
    chk("pau_en_t6", lvl(EN), 1);
    wait_done(20, dt);
    chk("pau_done_t", dt, 8);
    chk("pau_edges", en_edges, 4);
    chk("pau_q", int'(q_cnt), 4);
    tick();

    // Q stuck at 1
    stuck = 1'b1; stuck_v = 3'd1;
    start_run(3'd3);
    tick();
    chk("mis_err_c1", lvl(ERR), 0);
    tick();
    chk("mis_err_c2", lvl(ERR), 1);
    wait_done(20, dt);
    chk("mis_done_t", dt, 4);
    chk("mis_err_dn", lvl(ERR), 1);
    tick();
    ABORT = HI;
    tick();
    ABORT = LO;
    chk("abt_err_keep", lvl(ERR), 1);
    stuck = 1'b0; q_cnt = 3'd0;
    start_run(3'd1);
    chk("mis_err_clr", lvl(ERR), 0);
    wait_done(20, dt);
    chk("one_done_t", dt, 2);
    chk("one_err", lvl(ERR), 0);
    tick();

    // abort after 2 edges
    q_cnt = 3'd0;
    start_run(3'd5);
    tick(); tick();
    ABORT = HI;
    tick();
    ABORT = LO;
    chk("abt_en", lvl(EN), 0);
    chk("abt_busy", lvl(BUSY), 0);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (lvl(DONE) != 0) seen = 1;
    end
    chk("abt_nodone", seen, 0);

    // abort with start in idle
    START = HI; ABORT = HI;
    tick();
    START = LO; ABORT = LO;
    chk("col_busy", lvl(BUSY), 0);
    chk("col_en", lvl(EN), 0);

    // start while busy ignored
    q_cnt = 3'd0;
    start_run(3'd5);
    tick();
    steps_v = 3'd2;
    START = HI;
    tick(); tick();
    START = LO;
    wait_done(20, dt);
    chk("sib_done_t", dt, 6);
    chk("sib_edges", en_edges, 5);
    tick();

    // input threshold at VDD/2
    START = 8'd90;
    tick();
    chk("th_low", lvl(BUSY), 0);
    START = 8'd110;
    tick();
    START = LO;
    chk("th_high", lvl(BUSY), 1);
    ABORT = HI;
    tick();
    ABORT = LO;

    // async reset mid-run
    q_cnt = 3'd0;
    start_run(3'd5);
    tick();
    #3 RN = LO;
    #1;
    chk("arst_en", lvl(EN), 0);
    chk("arst_busy", lvl(BUSY), 0);
    tick();
    RN = HI;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (lvl(BUSY) != 0 || lvl(EN) != 0) seen = 1;
    end
    chk("arst_idle", seen, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
